// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial half subtractor.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Bits needed to index WIDTH positions; never below 1 so the counter stays declarable.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_half_sub16_hs_cell.sv
// Combinational 1-bit half subtractor: dif = x - bin, bout = borrow out.
module hs_cell (
  input  logic x,
  input  logic bin,
  output logic dif,
  output logic bout
);

  assign dif  = x ^ bin;
  assign bout = ~x & bin;

endmodule

// File: rtl/serial_half_sub16.sv
// Bit-serial half subtractor d = a - b (b is one bit), one bit per clock, start/busy/done handshake.
// Optional macro SERIAL_SUB_EARLY_EXIT_EN finishes as soon as the borrow clears.
module serial_half_sub16
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_x, cell_dif, cell_bout;
  logic finish;

  assign cell_x = work_q[cnt_q];

  hs_cell u_cell (
    .x    (cell_x),
    .bin  (brw_q),
    .dif  (cell_dif),
    .bout (cell_bout)
  );

`ifdef SERIAL_SUB_EARLY_EXIT_EN
  // Once the borrow dies the untouched upper bits of work already hold the answer.
  assign finish = (cnt_q == LAST) || !cell_bout;
`else
  assign finish = (cnt_q == LAST);
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    d_d     = d_q;
    bo_d    = bo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a;
          brw_d   = b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[cnt_q] = cell_dif;
        brw_d         = cell_bout;
        if (finish) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        d_d     = work_q;
        bo_d    = brw_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_half_sub16.sv
// Self-checking bench for serial_half_sub16: vector table, handshake corner cases, back-to-back random run.
module tb_serial_half_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic        b;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  serial_half_sub16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic        b;
    logic [15:0] exp_d;
    logic        exp_bo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clocks from start acceptance to the cycle in which done is high.
  function automatic int exp_latency(input logic [15:0] ia, input logic ib);
`ifdef SERIAL_SUB_EARLY_EXIT_EN
    if (!ib) return 2;
    for (int k = 0; k < 16; k++)
      if (ia[k]) return k + 2;
    return 17;
`else
    return 17;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic [15:0] ia, input logic ib,
                        output logic [15:0] od, output logic obo,
                        output int lat, output int busy_n, output int done_cyc);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    a      = 16'($urandom);
    b      = 1'($urandom);
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    od       = d;
    obo      = bo;
    done_cyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [15:0] rd;
    logic        rbo;
    int          lat, busy_n, dcyc, prev_cyc, dones, glitch;
    logic [15:0] first_d;
    logic [15:0] ra;
    logic        rb;

    vecs[0] = '{16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[1] = '{16'hFFFF, 1'b1, 16'hFFFE, 1'b0};
    vecs[2] = '{16'h1234, 1'b0, 16'h1234, 1'b0};
    vecs[3] = '{16'h0100, 1'b1, 16'h00FF, 1'b0};
    vecs[4] = '{16'h8000, 1'b1, 16'h7FFF, 1'b0};
    vecs[5] = '{16'h0001, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{16'h0000, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_d", {16'd0, d}, 32'd0);
    check("rst_bo", {31'd0, bo}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, rd, rbo, lat, busy_n, dcyc);
      check($sformatf("vec%0d_d", i), {16'd0, rd}, {16'd0, vecs[i].exp_d});
      check($sformatf("vec%0d_bo", i), {31'd0, rbo}, {31'd0, vecs[i].exp_bo});
      check($sformatf("vec%0d_lat", i), lat, exp_latency(vecs[i].a, vecs[i].b));
      check($sformatf("vec%0d_busy_cycles", i), busy_n, exp_latency(vecs[i].a, vecs[i].b));
      @(negedge clk);
    end

    // A start raised while RUN is in progress must be dropped.
    start = 1'b1; a = 16'h0008; b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; glitch = 0; first_d = '0;
    for (int n = 1; n < 60; n++) begin
      if (n == 3) begin
        start = 1'b1; a = 16'h5555; b = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) first_d = d;
      end
      if (dones == 0 && !busy) glitch++;
    end
    check("ign_done_count", dones, 1);
    check("ign_d", {16'd0, first_d}, 32'h0007);
    check("ign_busy_glitch", glitch, 0);

    // Reset with cnt=5 aborts without a done pulse.
    start = 1'b1; a = 16'h0000; b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_d", {16'd0, d}, 32'd0);
    check("abort_bo", {31'd0, bo}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(16'h0003, 1'b1, rd, rbo, lat, busy_n, dcyc);
    check("post_abort_d", {16'd0, rd}, 32'h0002);
    check("post_abort_bo", {31'd0, rbo}, 32'd0);

    // Back-to-back: each start issued in the IDLE cycle that carries done.
    @(negedge clk);
    prev_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rb = 1'($urandom);
      run_op(ra, rb, rd, rbo, lat, busy_n, dcyc);
      check($sformatf("b2b%0d_d", i), {16'd0, rd}, {16'd0, 16'(ra - {15'd0, rb})});
      check($sformatf("b2b%0d_bo", i), {31'd0, rbo}, {31'd0, (ra == 16'h0000) && rb});
      if (i > 0)
        check($sformatf("b2b%0d_gap", i), dcyc - prev_cyc, exp_latency(ra, rb) + 1);
      prev_cyc = dcyc;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_half_sub16.md
Name: serial_half_sub16

Overview:
- Bit-serial half subtractor: computes D = A - B, where A is WIDTH bits and B is 1 bit, and also produces a borrow-out.
- Processes one bit per clock using a start/busy/done handshake.
- Inverse-direction companion of the combinational 16-bit half-adder incrementer in the add/sub datapath.
- Used where area matters more than latency: decrement paths, counter underflow checks.

Parameters:
- WIDTH, 16: operand and result width in bits. Legal range is 2..64.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request. Sampled only in IDLE.
- a, input, WIDTH: minuend. Captured on the accepted start.
- b, input, 1: subtrahend bit. Captured on the accepted start.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse when d/bo are valid.
- d, output, WIDTH: difference, registered. Holds until the next completion.
- bo, output, 1: borrow-out, registered. Holds until the next completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - d=0, bo=0, busy=0, done=0.
  - Internal work register, borrow and cnt are cleared.
  - rst has priority over every other input, including mid-RUN. An aborted operation produces no done pulse.
- State IDLE:
  - If start=1: work <= a, brw <= b, cnt <= 0, go to RUN.
  - Otherwise stay in IDLE.
- State RUN, with i = cnt and x = work[i]:
  - work[i] <= x ^ brw
  - brw <= ~x & brw
  - cnt <= cnt + 1
  - Go to DONE when cnt == WIDTH-1. Otherwise stay in RUN.
  - Bits above i are untouched: they still hold the a bits.
- State DONE (exactly one cycle):
  - d <= work, bo <= brw, done=1, go to IDLE.
  - done is asserted in the same cycle that d/bo update.
- Latency:
  - Start sampled at edge E0; done is high in the cycle after edge E(WIDTH+1).
  - With the default WIDTH=16, that is 17 clocks.
  - Throughput is one operation per WIDTH+2 clocks.
- start while busy=1 (RUN or DONE) is ignored, not queued. The IDLE cycle after DONE can accept a new start.
- a and b may change freely after acceptance; only the captured values are used.
- Arithmetic is modulo 2^WIDTH:
  - a=0, b=1 wraps to all-ones with bo=1.
  - bo=1 if and only if a=0 and b=1.
- cnt is ceil(log2(WIDTH)) bits wide and never wraps during an operation.

Optional Feature:
- Macro: SERIAL_SUB_EARLY_EXIT_EN.
- Defined:
  - In RUN, the FSM also goes to DONE when the next borrow value (~x & brw) is 0.
  - Remaining upper bits of work already equal a, so the result is unchanged.
  - Latency is k+2 clocks, where k is the index of the bit at which the borrow clears.
  - If b=0, latency is 2 clocks.
  - The worst case (a=0, b=1) stays at WIDTH+1 clocks.
- Undefined: fixed WIDTH+1 latency regardless of data.
- d/bo values are identical in both builds; only the done timing differs.

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE} (2-bit encoding);
  - the default WIDTH constant;
  - a function computing the cnt width.
- Sub-module hs_cell: combinational 1-bit half-subtractor with inputs x and bin, outputs dif = x^bin and bout = ~x & bin.
  - Instantiated once, indexed by cnt.
- FSM, counter and registers live in the top module.

Test Plan:
- Wrap case: reset 2 cycles, then start with a=16'h0000, b=1. Expect d=16'hFFFF, bo=1, done exactly 17 clocks after start, busy high for 17 cycles.
- Plain decrement: a=16'hFFFF, b=1. Expect d=16'hFFFE, bo=0. With SERIAL_SUB_EARLY_EXIT_EN, done arrives after 2 clocks.
- Zero subtrahend and long borrow chain:
  - a=16'h1234, b=0: expect d=16'h1234, bo=0 (latency 17, or 2 with the macro).
  - a=16'h0100, b=1: expect d=16'h00FF, bo=0 (latency 17, or 10 with the macro).
- Ignored start: pulse start with a=16'h5555 while RUN is processing a=16'h0008, b=1. Expect only one done, with d=16'h0007. The second request is dropped and busy never glitches.
- Reset mid-operation: assert rst at cnt=5 during a=16'h0000, b=1. Expect next cycle state IDLE, d=0, bo=0, busy=0, no done pulse. A following start with a=16'h0003, b=1 yields d=16'h0002.
- Back-to-back: issue start on the first IDLE cycle after each done, for 100 random a/b. Every d/bo must match a model of (a - b) mod 2^16 and borrow = (a==0 & b==1). The gap between done pulses is exactly 18 clocks in the non-macro build.
